// File: rtl/tx_scheduler.sv
// Two-requester word scheduler feeding an MSB-first serial shifter.
// Round-robin arbitration on contention; abort drops the word in flight.
module tx_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             shift_en,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic             tdo,
  output logic             busy,
  output logic             done,
  output logic             owner
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    count;
  logic             rr;
  logic             pick;

  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !reset) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign pick = grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      rr        <= 1'b0;
      tdo       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            state     <= LOAD;
            busy      <= 1'b1;
            owner     <= pick;
            shift_reg <= pick ? data1 : data0;
            count     <= CW'(WIDTH);
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            tdo   <= 1'b0;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            tdo   <= 1'b0;
          end else if (shift_en && count != '0) begin
            tdo       <= shift_reg[WIDTH-1];
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            count     <= count - CW'(1);
            // last bit leaves on this edge
            if (count == CW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          rr    <= ~owner;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler: stimulus pushes expected words,
// negedge monitors collect serial bits and compare at word end.
module tb_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] data0, data1;
  logic        shift_en, abort;
  logic [1:0]  grant;
  logic        tdo, busy, done, owner;

  logic [1:0]  req8;
  logic [7:0]  data08, data18;
  logic        shift_en8;
  logic [1:0]  grant8;
  logic        tdo8, busy8, done8, owner8;

  always #5 clk = ~clk;

  tx_scheduler #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1),
    .shift_en(shift_en), .abort(abort),
    .grant(grant), .tdo(tdo), .busy(busy),
    .done(done), .owner(owner)
  );

  tx_scheduler #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8),
    .data0(data08), .data1(data18),
    .shift_en(shift_en8), .abort(1'b0),
    .grant(grant8), .tdo(tdo8), .busy(busy8),
    .done(done8), .owner(owner8)
  );

  typedef struct {
    logic [1:0]  g;
    logic        o;
    logic        d;
    int          nb;
    logic [31:0] w;
    int          lat;
  } item_t;

  item_t q[$];
  item_t q8[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [1:0] g, input logic o,
                               input logic d, input int nb,
                               input logic [31:0] w, input int lat);
    item_t it;
    it.g = g; it.o = o; it.d = d;
    it.nb = nb; it.w = w; it.lat = lat;
    return it;
  endfunction

  // 32-bit monitor
  logic [31:0] cap;
  int          nb, lat;
  bit          pend = 0, in_txn = 0;
  logic [1:0]  g_obs;
  logic        o_obs;

  task automatic end_txn(input logic d);
    item_t e;
    in_txn = 0;
    if (q.size() == 0) begin
      chk("unexpected_word", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk("grant", {30'd0, g_obs}, {30'd0, e.g});
    chk("owner", {31'd0, o_obs}, {31'd0, e.o});
    chk("done_seen", {31'd0, d}, {31'd0, e.d});
    chk("bit_count", nb, e.nb);
    chk("word", cap, e.w);
    if (e.d) chk("latency", lat, e.lat);
    else chk("tdo_after_abort", {31'd0, tdo}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (pend) begin
      cap = {cap[30:0], tdo};
      nb++;
    end
    pend = 0;
    if (in_txn) begin
      lat++;
      if (lat == 1) begin
        o_obs = owner;
        chk("grant_one_cycle", {30'd0, grant}, 32'd0);
      end
      if (done) end_txn(1'b1);
      else if (!busy) end_txn(1'b0);
    end
    if (!in_txn && grant != 2'b00) begin
      in_txn = 1; g_obs = grant;
      lat = 0; nb = 0; cap = '0;
    end else if (in_txn && lat >= 2 && busy && !done &&
                 shift_en && !abort && !reset) begin
      pend = 1;
    end
  end

  // 8-bit monitor
  logic [7:0] cap8;
  int         nb8, lat8;
  bit         pend8 = 0, on8 = 0;
  logic [1:0] g8_obs;

  always @(negedge clk) begin
    item_t e;
    if (pend8) begin
      cap8 = {cap8[6:0], tdo8};
      nb8++;
    end
    pend8 = 0;
    if (on8) begin
      lat8++;
      if (done8) begin
        on8 = 0;
        if (q8.size() == 0) begin
          chk("unexpected_word8", 32'd1, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("grant8", {30'd0, g8_obs}, {30'd0, e.g});
          chk("bit_count8", nb8, e.nb);
          chk("word8", {24'd0, cap8}, e.w);
          chk("latency8", lat8, e.lat);
        end
      end
    end
    if (!on8 && grant8 != 2'b00) begin
      on8 = 1; g8_obs = grant8;
      lat8 = 0; nb8 = 0; cap8 = '0;
    end else if (on8 && lat8 >= 2 && busy8 && !done8 &&
                 shift_en8 && !reset) begin
      pend8 = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; req = 0; data0 = 0; data1 = 0;
    shift_en = 0; abort = 0;
    req8 = 0; data08 = 0; data18 = 0; shift_en8 = 0;
    cyc(3);
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_tdo", {31'd0, tdo}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);

    // first word right after reset, plus the 8-bit instance
    cyc(1);
    reset = 0;
    req = 2'b01; data0 = 32'hA5A5_0F0F; shift_en = 1;
    req8 = 2'b10; data18 = 8'h3C; shift_en8 = 1;
    q.push_back(mk(2'b01, 0, 1, 32, 32'hA5A5_0F0F, 34));
    q8.push_back(mk(2'b10, 1, 1, 8, 32'h0000_003C, 10));
    cyc(1);
    req = 0; req8 = 0;
    cyc(40);

    // contention alternates from rr=0
    reset = 1;
    cyc(1);
    reset = 0;
    req = 2'b11; data0 = 32'h0000_0001; data1 = 32'h8000_0000;
    q.push_back(mk(2'b01, 0, 1, 32, 32'h0000_0001, 34));
    q.push_back(mk(2'b10, 1, 1, 32, 32'h8000_0000, 34));
    q.push_back(mk(2'b01, 0, 1, 32, 32'h0000_0001, 34));
    cyc(71);
    req = 0;
    cyc(40);

    // shift_en toggling, first SHIFT cycle idle
    data0 = 32'hFFFF_FFFF;
    q.push_back(mk(2'b01, 0, 1, 32, 32'hFFFF_FFFF, 66));
    for (int i = 0; i < 72; i++) begin
      req = (i == 0) ? 2'b01 : 2'b00;
      shift_en = (i % 2 == 1);
      cyc(1);
    end
    shift_en = 1;

    // abort after 10 bits; rr is 1 so contention picks requester 1
    req = 2'b11; data0 = 32'h0; data1 = 32'hDEAD_BEEF;
    q.push_back(mk(2'b10, 1, 0, 10, 32'h0000_037A, 0));
    cyc(1);
    req = 0;
    cyc(11);
    abort = 1;
    q.push_back(mk(2'b10, 1, 1, 32, 32'hDEAD_BEEF, 34));
    cyc(1);
    abort = 0; req = 2'b11;
    cyc(1);
    req = 0;
    cyc(40);

    // reset after 5 bits, then immediate grant
    req = 2'b10; data1 = 32'hF800_0000;
    q.push_back(mk(2'b10, 1, 0, 5, 32'h0000_001F, 0));
    cyc(1);
    req = 0;
    cyc(6);
    reset = 1;
    cyc(1);
    reset = 0; req = 2'b01; data0 = 32'h1234_5678;
    q.push_back(mk(2'b01, 0, 1, 32, 32'h1234_5678, 34));
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_tdo", {31'd0, tdo}, 32'd0);
    chk("post_rst_owner", {31'd0, owner}, 32'd1 ^ 32'd1);
    cyc(1);
    req = 0;
    cyc(40);

    chk("drain32", q.size(), 32'd0);
    chk("drain8", q8.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
